// File: rtl/vein_match_pkg.sv
// ----------------------------------------------------------------------------
// vein_match_pkg
// Definitions shared by the finger-vein matching path: the score-prep stage,
// the fixed-point divider (DivideNum) and their benches.
//   DIV_N             : width of counters and of the divider operands
//   SCORE_SCALE_SHIFT : fixed-point shift of the score (1 << shift == 1.0)
//   state_t           : state encoding of the score-prep sequencer
// ----------------------------------------------------------------------------
package vein_match_pkg;

  localparam int DIV_N             = 16;
  localparam int SCORE_SCALE_SHIFT = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // waiting for the first beat of a frame
    ST_ACCUM = 2'd1,  // frame in progress, counting overlap/union
    ST_ISSUE = 2'd2   // operands presented, waiting for the divider
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// W-bit up counter that sticks at all-ones instead of wrapping, with a
// synchronous clear.
// Ports:
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset, clears the count
//   clr        : synchronous clear (wins over inc)
//   inc        : add one this cycle, unless already saturated
//   count_next : value the counter takes on the coming edge; lets the
//                owner capture a total that includes the current increment
// ----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count_next
);

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] CNT_ONE = W'(1);

  logic [W-1:0] count_reg;

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (inc && (count_reg != CNT_MAX)) begin
      count_next = count_reg + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/match_score_prep.sv
// ----------------------------------------------------------------------------
// match_score_prep
// Streaming stage in front of the fixed-point divider. Counts, per frame,
// overlap pixels (template AND probe vein) and union pixels (template OR
// probe vein), then presents
//   dividend = min(overlap << SCALE_SHIFT, 2^N-1)
//   divisor  = union (or 1 when the union is empty, with dividend forced 0)
// and holds div_enable until the divider raises div_done.
// Ports:
//   clk, reset   : clock and synchronous active-high reset
//   pix_valid/pix_ready/pix_last : pixel beat handshake, last beat of frame
//   tmpl_bit, probe_bit          : vein bits for the current pixel
//   div_enable, dividend, divisor: divider request and operands
//   div_done     : divider completion level, only looked at while issuing
//   frame_done   : one-cycle pulse after the divider hand-off completes
//   score_empty  : last frame had an empty union (score defined as 0)
// ----------------------------------------------------------------------------
module match_score_prep
  import vein_match_pkg::*;
#(
  parameter int N           = DIV_N,
  parameter int SCALE_SHIFT = SCORE_SCALE_SHIFT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pix_valid,
  output logic         pix_ready,
  input  logic         pix_last,
  input  logic         tmpl_bit,
  input  logic         probe_bit,
  output logic         div_enable,
  output logic [N-1:0] dividend,
  output logic [N-1:0] divisor,
  input  logic         div_done,
  output logic         frame_done,
  output logic         score_empty
);

  localparam logic [N-1:0] CNT_MAX = '1;
  localparam logic [N-1:0] CNT_ONE = N'(1);

  state_t       state_reg;
  logic         pix_ready_reg;
  logic         div_enable_reg;
  logic [N-1:0] dividend_reg;
  logic [N-1:0] divisor_reg;
  logic         frame_done_reg;
  logic         score_empty_reg;

  logic         accept;
  logic         handoff;
  logic         ovl_inc;
  logic         uni_inc;
  logic [N-1:0] ovl_next;
  logic [N-1:0] uni_next;
  logic [N-1:0] scaled_sat;
  logic [N-1:0] dividend_next;
  logic [N-1:0] divisor_next;
  logic         empty_next;

  // pix_ready is registered and is only high outside ISSUE, so a beat can
  // never be accepted while the divider is busy.
  assign accept  = pix_valid & pix_ready_reg;
  assign handoff = (state_reg == ST_ISSUE) & div_done;
  assign ovl_inc = accept & tmpl_bit & probe_bit;
  assign uni_inc = accept & (tmpl_bit | probe_bit);

  // Counters are cleared when the divider hand-off finishes, so the next
  // frame always starts from zero.
  sat_counter #(.W(N)) u_ovl_cnt (
    .clk        (clk),
    .reset      (reset),
    .clr        (handoff),
    .inc        (ovl_inc),
    .count_next (ovl_next)
  );

  sat_counter #(.W(N)) u_uni_cnt (
    .clk        (clk),
    .reset      (reset),
    .clr        (handoff),
    .inc        (uni_inc),
    .count_next (uni_next)
  );

  // Scale the overlap count at full width first, then clip to N bits, so a
  // large overlap saturates the score instead of dropping high bits.
  generate
    if (SCALE_SHIFT > 0) begin : g_scale
      logic [N+SCALE_SHIFT-1:0] ovl_wide;
      assign ovl_wide   = {{SCALE_SHIFT{1'b0}}, ovl_next} << SCALE_SHIFT;
      assign scaled_sat = (|ovl_wide[N+SCALE_SHIFT-1:N]) ? CNT_MAX : ovl_wide[N-1:0];
    end else begin : g_noscale
      assign scaled_sat = ovl_next;
    end
  endgenerate

  // Operands from the final counts (including the pix_last beat). An empty
  // union would be a divide-by-zero; present 0/1 and flag it instead.
  always_comb begin
    empty_next    = (uni_next == '0);
    dividend_next = scaled_sat;
    divisor_next  = uni_next;
    if (empty_next) begin
      dividend_next = '0;
      divisor_next  = CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      pix_ready_reg   <= 1'b0;
      div_enable_reg  <= 1'b0;
      dividend_reg    <= '0;
      divisor_reg     <= '0;
      frame_done_reg  <= 1'b0;
      score_empty_reg <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE, ST_ACCUM: begin
          pix_ready_reg <= 1'b1;
          if (accept) begin
            if (pix_last) begin
              state_reg       <= ST_ISSUE;
              pix_ready_reg   <= 1'b0;
              div_enable_reg  <= 1'b1;
              dividend_reg    <= dividend_next;
              divisor_reg     <= divisor_next;
              score_empty_reg <= empty_next;
            end else begin
              state_reg <= ST_ACCUM;
            end
          end
        end
        ST_ISSUE: begin
          if (div_done) begin
            state_reg      <= ST_IDLE;
            pix_ready_reg  <= 1'b1;
            div_enable_reg <= 1'b0;
            frame_done_reg <= 1'b1;
          end
        end
        default: begin
          state_reg      <= ST_IDLE;
          pix_ready_reg  <= 1'b0;
          div_enable_reg <= 1'b0;
        end
      endcase
    end
  end

  assign pix_ready   = pix_ready_reg;
  assign div_enable  = div_enable_reg;
  assign dividend    = dividend_reg;
  assign divisor     = divisor_reg;
  assign frame_done  = frame_done_reg;
  assign score_empty = score_empty_reg;

endmodule
